pcis_read_scheduler: RTL and testbench

- Sits between the shell's DMA PCIS read-address/read-data channels and NUM_APPS AOSPacket read sources.
- Queues up to CMD_DEPTH read bursts and serves them strictly in order, one burst at a time.
- Routes each burst to the app selected by the address, muxes that app's packets onto the R channel and back-pressures only that app.
- Replaces single-burst, single-source read handling with a queued, shared read path.

---
 rtl/pcis_read_scheduler_pkg.sv | 28 ++
 rtl/pcis_read_scheduler_cmd_fifo.sv | 68 ++++++
 rtl/pcis_read_scheduler.sv | 166 ++++++++++++++++
 tb/tb_pcis_read_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcis_read_scheduler_pkg.sv
// Shared types for the PCIS read scheduler: AOSPacket source record, queued AR
// command record and read-response codes.
package pcis_read_scheduler_pkg;

  localparam int AMI_APP_BITS  = 3;
  localparam int AOS_SLOT_BITS = 4;

  localparam logic [1:0] PCIS_RRESP_OKAY   = 2'b00;
  localparam logic [1:0] PCIS_RRESP_SLVERR = 2'b10;

  typedef struct packed {
    logic                     valid;
    logic [511:0]             data;
    logic [AOS_SLOT_BITS-1:0] slot;
  } AOSPacket;

  typedef struct packed {
    logic [5:0]              id;
    logic [AMI_APP_BITS-1:0] app;
    logic [7:0]              len;
  } pcis_rd_cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } rd_state_e;

endpackage

// File: rtl/pcis_read_scheduler_cmd_fifo.sv
// pcis_cmd_fifo: synchronous FIFO of queued AR commands with full/empty/count.
// Push while full and pop while empty are ignored.
module pcis_cmd_fifo
  import pcis_read_scheduler_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  pcis_rd_cmd_t  push_cmd,
  input  logic          pop,
  output pcis_rd_cmd_t  head_cmd,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  pcis_rd_cmd_t  mem_q [DEPTH];
  pcis_rd_cmd_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_cmd = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_cmd;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pcis_read_scheduler.sv
// Queued, in-order PCIS read scheduler routing each burst to one AOSPacket source.
// Define PCIS_RD_ERR_RESP_EN to answer out-of-range apps with SLVERR beats.
module pcis_read_scheduler
  import pcis_read_scheduler_pkg::*;
#(
  parameter  int NUM_APPS     = 4,
  parameter  int CMD_DEPTH    = 4,
  parameter  int APP_ADDR_LSB = 13,
  localparam int CNT_W        = $clog2(CMD_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           sh_cl_dma_pcis_arid,
  input  logic [63:0]          sh_cl_dma_pcis_araddr,
  input  logic [7:0]           sh_cl_dma_pcis_arlen,
  input  logic [2:0]           sh_cl_dma_pcis_arsize,
  input  logic                 sh_cl_dma_pcis_arvalid,
  output logic                 cl_sh_dma_pcis_arready,
  output logic [5:0]           cl_sh_dma_pcis_rid,
  output logic [511:0]         cl_sh_dma_pcis_rdata,
  output logic [1:0]           cl_sh_dma_pcis_rresp,
  output logic                 cl_sh_dma_pcis_rlast,
  output logic                 cl_sh_dma_pcis_rvalid,
  input  logic                 sh_cl_dma_pcis_rready,
  input  AOSPacket             app_packet_in [NUM_APPS],
  output logic [NUM_APPS-1:0]  app_packet_ready,
  output logic                 rd_busy,
  output logic [CNT_W-1:0]     rd_cmd_count
);

  rd_state_e               state_q, state_d;
  logic [5:0]              cur_id_q, cur_id_d;
  logic [AMI_APP_BITS-1:0] cur_app_q, cur_app_d;
  logic [7:0]              cur_len_q, cur_len_d;

  pcis_rd_cmd_t            push_cmd, head_cmd;
  logic                    q_full, q_empty, q_push, q_pop;
  logic [CNT_W-1:0]        q_count;

  logic [AMI_APP_BITS-1:0] sel_app;
  logic                    app_err;
  logic                    src_valid;
  logic [511:0]            src_data;
  logic                    beat, last_beat;
  logic                    unused_inputs;

  assign cl_sh_dma_pcis_arready = !q_full && !rst;
  assign q_push   = sh_cl_dma_pcis_arvalid && cl_sh_dma_pcis_arready;
  assign push_cmd = '{id:  sh_cl_dma_pcis_arid,
                      app: sh_cl_dma_pcis_araddr[APP_ADDR_LSB +: AMI_APP_BITS],
                      len: sh_cl_dma_pcis_arlen};

  pcis_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push),
    .push_cmd (push_cmd),
    .pop      (q_pop),
    .head_cmd (head_cmd),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

`ifdef PCIS_RD_ERR_RESP_EN
  localparam logic [AMI_APP_BITS:0] NUM_APPS_W = (AMI_APP_BITS + 1)'(NUM_APPS);
  assign sel_app = cur_app_q;
  assign app_err = ({1'b0, cur_app_q} >= NUM_APPS_W);
`else
  // Out-of-range apps alias onto the low app-number bits.
  localparam int                      SEL_BITS = $clog2(NUM_APPS);
  localparam logic [AMI_APP_BITS-1:0] APP_MASK = AMI_APP_BITS'((1 << SEL_BITS) - 1);
  assign sel_app = cur_app_q & APP_MASK;
  assign app_err = 1'b0;
`endif

  always_comb begin
    src_valid     = 1'b0;
    src_data      = '0;
    unused_inputs = ^{sh_cl_dma_pcis_arsize, sh_cl_dma_pcis_araddr, cur_app_q};
    for (int i = 0; i < NUM_APPS; i++) begin
      unused_inputs = unused_inputs ^ (^app_packet_in[i].slot);
      if (sel_app == AMI_APP_BITS'(i)) begin
        src_valid = app_packet_in[i].valid;
        src_data  = app_packet_in[i].data;
      end
    end
  end

  // R channel is a combinational view of the active burst and its source.
  always_comb begin
    cl_sh_dma_pcis_rid    = '0;
    cl_sh_dma_pcis_rdata  = '0;
    cl_sh_dma_pcis_rresp  = PCIS_RRESP_OKAY;
    cl_sh_dma_pcis_rlast  = 1'b0;
    cl_sh_dma_pcis_rvalid = 1'b0;
    app_packet_ready      = '0;
    rd_busy               = 1'b0;
    if (!rst && state_q == ST_SEND) begin
      cl_sh_dma_pcis_rid   = cur_id_q;
      cl_sh_dma_pcis_rlast = (cur_len_q == 8'd0);
      rd_busy              = 1'b1;
      if (app_err) begin
        cl_sh_dma_pcis_rvalid = 1'b1;
        cl_sh_dma_pcis_rresp  = PCIS_RRESP_SLVERR;
      end else begin
        cl_sh_dma_pcis_rvalid = src_valid;
        cl_sh_dma_pcis_rdata  = src_data;
        for (int i = 0; i < NUM_APPS; i++) begin
          if (sel_app == AMI_APP_BITS'(i)) app_packet_ready[i] = sh_cl_dma_pcis_rready;
        end
      end
    end
  end

  assign rd_cmd_count = rst ? '0 : q_count;
  assign beat         = cl_sh_dma_pcis_rvalid && sh_cl_dma_pcis_rready;
  assign last_beat    = beat && (cur_len_q == 8'd0);
  assign q_pop        = !rst && !q_empty && ((state_q == ST_IDLE) || last_beat);

  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    cur_app_d = cur_app_q;
    cur_len_d = cur_len_q;
    case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          state_d   = ST_SEND;
          cur_id_d  = head_cmd.id;
          cur_app_d = head_cmd.app;
          cur_len_d = head_cmd.len;
        end
      end
      ST_SEND: begin
        if (last_beat) begin
          if (!q_empty) begin
            cur_id_d  = head_cmd.id;
            cur_app_d = head_cmd.app;
            cur_len_d = head_cmd.len;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (beat) begin
          cur_len_d = cur_len_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_id_q  <= '0;
      cur_app_q <= '0;
      cur_len_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      cur_app_q <= cur_app_d;
      cur_len_q <= cur_len_d;
    end
  end

endmodule

// File: tb/tb_pcis_read_scheduler.sv
// Bench for pcis_read_scheduler: directed AR sequences with randomized source/R
// handshakes, checked against a burst-queue reference model.
module tb_pcis_read_scheduler;
  import pcis_read_scheduler_pkg::*;

  localparam int NUM_APPS     = 4;
  localparam int CMD_DEPTH    = 4;
  localparam int APP_ADDR_LSB = 13;
  localparam int CNT_W        = $clog2(CMD_DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst;
  logic [5:0]          arid;
  logic [63:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic                arvalid;
  logic                arready;
  logic [5:0]          rid;
  logic [511:0]        rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  AOSPacket            app_packet_in [NUM_APPS];
  logic [NUM_APPS-1:0] app_packet_ready;
  logic                rd_busy;
  logic [CNT_W-1:0]    rd_cmd_count;

  always #5 clk = ~clk;

  pcis_read_scheduler #(.NUM_APPS(NUM_APPS), .CMD_DEPTH(CMD_DEPTH), .APP_ADDR_LSB(APP_ADDR_LSB)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .sh_cl_dma_pcis_arid    (arid),
    .sh_cl_dma_pcis_araddr  (araddr),
    .sh_cl_dma_pcis_arlen   (arlen),
    .sh_cl_dma_pcis_arsize  (arsize),
    .sh_cl_dma_pcis_arvalid (arvalid),
    .cl_sh_dma_pcis_arready (arready),
    .cl_sh_dma_pcis_rid     (rid),
    .cl_sh_dma_pcis_rdata   (rdata),
    .cl_sh_dma_pcis_rresp   (rresp),
    .cl_sh_dma_pcis_rlast   (rlast),
    .cl_sh_dma_pcis_rvalid  (rvalid),
    .sh_cl_dma_pcis_rready  (rready),
    .app_packet_in          (app_packet_in),
    .app_packet_ready       (app_packet_ready),
    .rd_busy                (rd_busy),
    .rd_cmd_count           (rd_cmd_count)
  );

  typedef struct {
    logic [5:0] id;
    int         app_eff;
    int         len;
    bit         err;
  } burst_t;

  burst_t exp_q[$];
  int beat_idx;
  int src_seq [NUM_APPS];
  int exp_seq [NUM_APPS];
  int checks, passes, cyc;
  int beats_seen, first_beat_cyc, last_beat_cyc, ar_hs_cyc;
  bit ar_hs;
  bit valid_rand, rready_rand;
  logic rready_fix;
  logic [5:0] ar_id;
  int ar_app, ar_len;
  logic arready_s, busy_s, rvalid_s;
  logic [CNT_W-1:0] cnt_s;

  function automatic logic [511:0] mkdata(input int app, input int seq);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'(app * 32'h1000_0000 + seq * 16 + k);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    logic [NUM_APPS-1:0] rdy_s, vld_s;
    logic [NUM_APPS-1:0] mask;
    bit beat_now, hs_now;
    rready = rready_rand ? 1'($urandom_range(0, 1)) : rready_fix;
    for (int i = 0; i < NUM_APPS; i++) begin
      app_packet_in[i].valid = valid_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      app_packet_in[i].data  = mkdata(i, src_seq[i]);
      app_packet_in[i].slot  = AOS_SLOT_BITS'(i);
    end
    #1;
    rdy_s = app_packet_ready;
    for (int i = 0; i < NUM_APPS; i++) vld_s[i] = app_packet_in[i].valid;
    arready_s = arready; busy_s = rd_busy; rvalid_s = rvalid; cnt_s = rd_cmd_count;
    beat_now = 0; hs_now = 0;
    if (rst) begin
      chk("rst_rvalid", rvalid, 0);
      chk("rst_arready", arready, 0);
      chk("rst_count", rd_cmd_count, 0);
      chk("rst_busy", rd_busy, 0);
      chk("rst_app_ready", app_packet_ready, 0);
      chk("rst_rlast_rid", {rlast, rid, rresp}, 0);
    end else begin
      mask = '0;
      if (exp_q.size() > 0 && !exp_q[0].err) mask[exp_q[0].app_eff] = 1'b1;
      chk("ready_other_apps", app_packet_ready & ~mask, 0);
      if (rvalid && rready) begin
        if (exp_q.size() == 0) chk("spurious_beat", 1, 0);
        else begin
          beat_now = 1;
          chk("beat_rid", rid, exp_q[0].id);
          chk("beat_rresp", rresp, exp_q[0].err ? 2'b10 : 2'b00);
          chk("beat_rlast", rlast, beat_idx == exp_q[0].len);
          chk("beat_rdata", rdata, exp_q[0].err ? 512'd0 : mkdata(exp_q[0].app_eff, exp_seq[exp_q[0].app_eff]));
          if (!exp_q[0].err) chk("beat_src_ready", app_packet_ready[exp_q[0].app_eff], 1);
        end
      end
      hs_now = arvalid && arready;
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      beat_idx = 0;
    end else begin
      if (beat_now) begin
        beats_seen++;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        if (!exp_q[0].err) exp_seq[exp_q[0].app_eff]++;
        if (beat_idx == exp_q[0].len) begin
          void'(exp_q.pop_front());
          beat_idx = 0;
        end else beat_idx++;
      end
      if (hs_now) begin
        burst_t b;
        b.id = ar_id; b.len = ar_len; b.app_eff = ar_app % NUM_APPS;
`ifdef PCIS_RD_ERR_RESP_EN
        b.err = (ar_app >= NUM_APPS);
`else
        b.err = 0;
`endif
        exp_q.push_back(b);
        ar_hs = 1; ar_hs_cyc = cyc;
      end
    end
    for (int i = 0; i < NUM_APPS; i++) if (vld_s[i] && rdy_s[i]) src_seq[i]++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_ar(input int id, input int app, input int len);
    ar_id = 6'(id); ar_app = app; ar_len = len;
    araddr = {$urandom, $urandom};
    araddr[APP_ADDR_LSB +: AMI_APP_BITS] = AMI_APP_BITS'(app);
    arid = 6'(id); arlen = 8'(len); arsize = 3'($urandom_range(0, 7));
    arvalid = 1'b1;
  endtask

  task automatic do_ar(input int id, input int app, input int len);
    set_ar(id, app, len);
    ar_hs = 0;
    for (int n = 0; n < 200 && !ar_hs; n++) tick();
    if (!ar_hs) chk("ar_handshake_timeout", 0, 1);
    arvalid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && exp_q.size() > 0; n++) tick();
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic start_test();
    beats_seen = 0; first_beat_cyc = -1; last_beat_cyc = -1;
  endtask

  initial begin
    int t_ar, total;
    checks = 0; passes = 0; cyc = 0; beat_idx = 0;
    for (int i = 0; i < NUM_APPS; i++) begin src_seq[i] = 0; exp_seq[i] = 0; end
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0;
    valid_rand = 0; rready_rand = 0; rready_fix = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", busy_s, 0);

    // Single burst, latency and rlast placement.
    start_test();
    do_ar(5, 2, 3);
    t_ar = ar_hs_cyc;
    drain(100);
    chk("t1_beats", beats_seen, 4);
    chk("t1_latency", first_beat_cyc - t_ar, 2);

    // Queue fill with R stalled, then bubble-free drain in order.
    rready_fix = 1'b0;
    start_test();
    total = 0;
    for (int k = 0; k < 5; k++) begin
      int l = $urandom_range(0, 3);
      do_ar(10 + k, k % NUM_APPS, l);
      total += l + 1;
    end
    set_ar(20, 1, 0);
    tick();
    chk("t2_arready_full", arready_s, 0);
    chk("t2_count", cnt_s, 4);
    chk("t2_busy", busy_s, 1);
    arvalid = 1'b0;
    rready_fix = 1'b1;
    drain(200);
    chk("t2_beats", beats_seen, total);
    chk("t2_no_bubble", last_beat_cyc - first_beat_cyc, total - 1);

    // Random back-pressure on a 16-beat burst, then mixed random bursts.
    valid_rand = 1; rready_rand = 1;
    start_test();
    do_ar(33, $urandom_range(0, NUM_APPS - 1), 15);
    drain(1000);
    chk("t3_beats", beats_seen, 16);
    start_test();
    total = 0;
    for (int k = 0; k < 6; k++) begin
      int l = $urandom_range(0, 20);
      do_ar(40 + k, $urandom_range(0, NUM_APPS - 1), l);
      total += l + 1;
    end
    drain(3000);
    chk("t3_rand_beats", beats_seen, total);

    // Reset in the middle of a burst with another one queued.
    valid_rand = 0; rready_rand = 0; rready_fix = 1'b1;
    start_test();
    do_ar(7, 1, 7);
    do_ar(8, 3, 2);
    for (int n = 0; n < 50 && beats_seen < 2; n++) tick();
    chk("t4_pre_rst_beats", beats_seen, 2);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("t4_post_count", cnt_s, 0);
    chk("t4_post_busy", busy_s, 0);
    chk("t4_post_rvalid", rvalid_s, 0);
    chk("t4_no_late_beats", beats_seen, 2);
    start_test();
    do_ar(9, 0, 5);
    drain(100);
    chk("t4_fresh_beats", beats_seen, 6);

    // Out-of-range app number.
    start_test();
    do_ar(12, 6, 1);
    drain(100);
    chk("t5_beats", beats_seen, 2);

    // Maximum burst length.
    start_test();
    do_ar(44, $urandom_range(0, NUM_APPS - 1), 255);
    drain(600);
    chk("t6_beats", beats_seen, 256);
    tick();
    chk("t6_idle_busy", busy_s, 0);
    chk("t6_idle_count", cnt_s, 0);
    chk("t6_idle_rvalid", rvalid_s, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
